// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions used by the fetch unit and control_unit.
package instr_fetch_unit_pkg;

  localparam int unsigned PC_W       = 8;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetchState_t;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] getOpcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small FIFO holding fetched {pc, instr} entries; flush empties it in one edge.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            pushData,
  output logic [DATA_W-1:0]            headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic              doPush;
  logic              doPop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign doPush   = push && !flush && (count < CNT_W'(DEPTH));
  assign doPop    = pop && !flush && (count != '0);
  assign headData = mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      if (doPush && !doPop)      count <= count + CNT_W'(1);
      else if (!doPush && doPop) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues sequential word reads, buffers responses, handles redirects.
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     fetch_en,
  output logic                                     imem_req,
  output logic [PC_W-1:0]                          imem_addr,
  input  logic [instr_fetch_unit_pkg::INSTR_W-1:0] imem_rdata,
  input  logic                                     redirect_valid,
  input  logic [PC_W-1:0]                          redirect_pc,
  output logic                                     if_valid,
  output logic [instr_fetch_unit_pkg::INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]                          if_pc,
  input  logic                                     id_ready
);

  import instr_fetch_unit_pkg::*;

  localparam int unsigned FIFO_W = INSTR_W + PC_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  fetchState_t        state;
  fetchState_t        stateNext;
  logic [PC_W-1:0]    pc;
  logic               epoch;
  logic               inflight;
  logic               inflightEpoch;
  logic [PC_W-1:0]    inflightAddr;
  logic [CNT_W-1:0]   count;
  logic [FIFO_W-1:0]  headData;
  logic [CNT_W:0]     occupancy;
  logic               ifPop;
  logic               respPush;

  assign ifPop     = if_valid && id_ready;
  assign respPush  = inflight && (inflightEpoch == epoch) && !redirect_valid;
  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? headData[INSTR_W-1:0] : '0;
  assign if_pc     = if_valid ? headData[FIFO_W-1:INSTR_W] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= stateNext;
  end

  // Next state and request strobe; a request only issues if its response is sure to fit.
  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(ifPop);
    case (state)
      BOOT: stateNext = RUN;
      RUN:  imem_req  = fetch_en && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
      default: stateNext = BOOT;
    endcase
  end

  // PC, epoch and outstanding-request tracking; redirect overrides sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      epoch         <= 1'b0;
      inflight      <= 1'b0;
      inflightEpoch <= 1'b0;
      inflightAddr  <= RESET_PC;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflightAddr  <= pc;
        inflightEpoch <= epoch;
      end
      if (redirect_valid) begin
        epoch <= ~epoch;
        pc    <= redirect_pc;
      end else if (imem_req) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (respPush),
    .pop      (ifPop),
    .flush    (redirect_valid),
    .pushData ({inflightAddr, imem_rdata}),
    .headData (headData),
    .count    (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random and directed stimulus vs. address-stream model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        id_ready;

  logic        feReq;
  logic [7:0]  feAddr;
  logic [31:0] feRdata;
  logic        feValid;
  logic [31:0] feInstr;
  logic [7:0]  fePc;

  int checks = 0;
  int failures = 0;
  int outstanding = 0;
  int feSeen = 0;

  logic [7:0] expDeliv[$];
  logic [7:0] expReq[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  instr_fetch_unit #(.PC_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) u_dutFe (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1),
    .imem_req(feReq), .imem_addr(feAddr), .imem_rdata(feRdata),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .if_valid(feValid), .if_instr(feInstr), .if_pc(fePc), .id_ready(1'b1)
  );

  function automatic logic [31:0] memData(input logic [7:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected request and delivery streams: consecutive addresses from a start point.
  task automatic loadStream(input logic [7:0] start);
    expDeliv.delete();
    expReq.delete();
    for (int k = 0; k < 1024; k++) begin
      expDeliv.push_back(start + 8'(k));
      expReq.push_back(start + 8'(k));
    end
    outstanding = 0;
  endtask

  // Memory model for the main DUT: data one cycle after the request.
  initial begin
    logic       pend;
    logic [7:0] addr;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      pend = rst_n && imem_req;
      addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = pend ? memData(addr) : $urandom;
    end
  end

  // Memory model for the RESET_PC=FE instance.
  initial begin
    logic       pend;
    logic [7:0] addr;
    feRdata = '0;
    forever begin
      @(negedge clk);
      pend = rst_n && feReq;
      addr = feAddr;
      @(posedge clk);
      #1;
      feRdata = pend ? memData(addr) : $urandom;
    end
  end

  // Monitor: compares each request and each accepted instruction against the model.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req) begin
          if (expReq.size() == 0) check("req_queue_empty", 32'(imem_addr), 32'hFFFF_FFFF);
          else begin
            e = expReq.pop_front();
            check("req_addr", 32'(imem_addr), 32'(e));
          end
          outstanding++;
        end
        if (if_valid && id_ready) begin
          if (expDeliv.size() == 0) check("deliv_queue_empty", 32'(if_pc), 32'hFFFF_FFFF);
          else begin
            e = expDeliv.pop_front();
            check("deliv_pc", 32'(if_pc), 32'(e));
            check("deliv_instr", if_instr, memData(e));
          end
          outstanding--;
        end
        if (!if_valid) begin
          check("idle_instr_zero", if_instr, 32'h0);
          check("idle_pc_zero", 32'(if_pc), 32'h0);
        end
        check("occupancy_le_depth", 32'(outstanding <= DEPTH), 32'h1);
        if (redirect_valid) begin
          check("redirect_no_req", 32'(imem_req), 32'h0);
          loadStream(redirect_pc);
        end
      end
    end
  end

  // Monitor for the wrapping instance: first four deliveries FE, FF, 00, 01.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && feValid && feSeen < 4) begin
        e = 8'hFE + 8'(feSeen);
        check("wrap_pc", 32'(fePc), 32'(e));
        check("wrap_instr", feInstr, memData(e));
        feSeen++;
      end
    end
  end

  // Stimulus.
  initial begin
    int  n;
    bit  found;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", 32'(if_pc), 32'h0);
    loadStream(8'h00);
    rst_n = 1'b1;

    // Startup latency: BOOT cycle, requests from cycle 1, first instruction in cycle 3.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("start_valid", 32'(if_valid), 32'(c >= 3));
      check("start_req", 32'(imem_req), 32'(c >= 1));
      if (c == 1) check("start_first_addr", 32'(imem_addr), 32'h0);
    end

    // Sustained one instruction per cycle.
    n = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (if_valid) n++;
    end
    check("throughput", 32'(n), 32'd20);

    // Decoder stall: buffer fills to DEPTH and requests stop.
    @(posedge clk); #1;
    id_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      check("stall_req_off", 32'(imem_req), 32'h0);
    end
    check("stall_buffered", 32'(outstanding), 32'd2);
    check("stall_valid", 32'(if_valid), 32'h1);
    @(posedge clk); #1;
    id_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Redirect to 8'h40.
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    @(negedge clk); #1;
    check("redir_cycle_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    check("redir_next_valid", 32'(if_valid), 32'h0);
    check("redir_next_req", 32'(imem_req), 32'h1);
    check("redir_next_addr", 32'(imem_addr), 32'h40);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk); #1;
      if (if_valid) begin
        found = 1'b1;
        check("redir_first_pc", 32'(if_pc), 32'h40);
      end
    end
    if (!found) check("redir_first_timeout", 32'h0, 32'h1);

    // Fetch disable: in-flight work drains, no new requests.
    @(posedge clk); #1;
    fetch_en = 1'b0;
    for (int f = 0; f < 6; f++) begin
      @(negedge clk); #1;
      check("fetch_off_req", 32'(imem_req), 32'h0);
      if (f >= 3) check("fetch_off_drained", 32'(if_valid), 32'h0);
    end
    @(posedge clk); #1;
    fetch_en = 1'b1;
    @(negedge clk); #1;
    check("fetch_on_req", 32'(imem_req), 32'h1);

    // Random traffic.
    for (int r = 0; r < 800; r++) begin
      @(posedge clk); #1;
      fetch_en       = ($urandom % 10) < 8;
      id_ready       = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc    = 8'($urandom);
    end

    // Reset mid-stream with a full buffer.
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    id_ready       = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_reset_full", 32'(outstanding), 32'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_addr", 32'(imem_addr), 32'h0);
    check("midrst_valid", 32'(if_valid), 32'h0);
    check("midrst_instr", if_instr, 32'h0);
    check("midrst_pc", 32'(if_pc), 32'h0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    loadStream(8'h00);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("midrst_boot_req", 32'(imem_req), 32'h0);
    @(negedge clk); #1;
    check("midrst_refetch_req", 32'(imem_req), 32'h1);
    check("midrst_refetch_addr", 32'(imem_addr), 32'h0);
    repeat (20) @(negedge clk);
    #1;
    check("wrap_seen", 32'(feSeen), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
